// File: rtl/g2_pkg.sv
// g2_pkg: shared types and helpers for the g2 photon-correlation histogrammer.
//   g2_state_e   - controller states
//   G2_RMW_DEPTH - depth of the bin read-modify-write pipeline
//   g2_bin_of    - binned delay plus histogram centre
//   g2_in_range  - bin lies inside 0..nbins-1
package g2_pkg;

  typedef enum logic [2:0] {CLR, IDLE, SCAN, DRAIN, DUMP} g2_state_e;

  localparam int G2_RMW_DEPTH = 3;

  // Wide signed carrier so the helpers work for any TS_W up to 63.
  typedef logic signed [63:0] g2_wide_t;

  function automatic g2_wide_t g2_bin_of(input g2_wide_t diff, input logic [4:0] shift,
                                         input g2_wide_t center);
    return (diff >>> shift) + center;
  endfunction

  function automatic logic g2_in_range(input g2_wide_t bin, input g2_wide_t nbins);
    return !bin[63] && (bin < nbins);
  endfunction

endpackage

// File: rtl/g2_hist_bank.sv
// g2_hist_bank: NBINS x CNT_W simple dual-port bin RAM with a 3-stage
// increment pipeline (read address / read data / write data+1).
// Optional macro G2_HIST_SATURATE_EN: increments stick at all-ones instead of wrapping.
// Ports:
//   clk, rst_n          clock, async active-low reset (pipeline only, RAM has none)
//   rd_addr             RAM read address (increment target or readout address)
//   inc_vld             this cycle's read starts an increment of rd_addr
//   clr_we, clr_addr    write zero to clr_addr (never concurrent with increments)
//   rd_data             registered RAM read data, one cycle after rd_addr
//   pipe_busy           increments still in flight
module g2_hist_bank import g2_pkg::*; #(
  parameter int BIN_AW = 10,
  parameter int CNT_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_AW-1:0] rd_addr,
  input  logic              inc_vld,
  input  logic              clr_we,
  input  logic [BIN_AW-1:0] clr_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              pipe_busy
);
  localparam int NBINS = 1 << BIN_AW;

  logic [CNT_W-1:0]        mem [NBINS];
  // vld_pipe[1]: read data stage, [2]: write stage, [3]: value written last cycle
  logic [G2_RMW_DEPTH:1]   vld_pipe;
  logic [BIN_AW-1:0]       s1_addr, s2_addr, s3_addr;
  logic [CNT_W-1:0]        s2_val, s3_val, base, nxt;

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (vld_pipe[2])  mem[s2_addr]  <= s2_val;
    else if (clr_we)  mem[clr_addr] <= '0;
  end

  // RAM data in stage 1 misses the write now in stage 2 (1 apart) and the
  // write that landed on the same edge as the read (2 apart): forward both,
  // newest first.
  always_comb begin
    base = rd_data;
    if (vld_pipe[2] && s2_addr == s1_addr)      base = s2_val;
    else if (vld_pipe[3] && s3_addr == s1_addr) base = s3_val;
`ifdef G2_HIST_SATURATE_EN
    nxt = (&base) ? base : base + 1'b1;
`else
    nxt = base + 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      s3_addr  <= '0;
      s2_val   <= '0;
      s3_val   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[G2_RMW_DEPTH-1:1], inc_vld};
      s1_addr  <= rd_addr;
      s2_addr  <= s1_addr;
      s2_val   <= nxt;
      s3_addr  <= s2_addr;
      s3_val   <= s2_val;
    end
  end

  assign pipe_busy = vld_pipe[1] | vld_pipe[2];

endmodule

// File: rtl/g2_histogrammer.sv
// g2_histogrammer: keeps a sliding window of recent a2 timestamps; every a1
// scans the window and bumps bin ((a1 - a2) >>> cfg_shift) + CENTER per pair.
// dump streams all bins out (clearing them) over a valid/ready port.
// Optional macro G2_HIST_SATURATE_EN (see g2_hist_bank): saturating bins.
// Ports:
//   clk, RST                    clock, async active-low reset
//   cfg_shift                   bin width shift, captured with a1
//   a1/a1V/a1R, a2/a2V/a2R      timestamp streams (a2 has priority)
//   dump                        readout request pulse
//   busy                        not IDLE
//   g2Dat/g2Idx/g2V/g2R/g2Last  readout stream
module g2_histogrammer import g2_pkg::*; #(
  parameter int TS_W      = 32,
  parameter int WIN_DEPTH = 16,
  parameter int BIN_AW    = 10,
  parameter int CNT_W     = 18,
  parameter int OUT_W     = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [4:0]        cfg_shift,
  input  logic [TS_W-1:0]   a1,
  input  logic              a1V,
  output logic              a1R,
  input  logic [TS_W-1:0]   a2,
  input  logic              a2V,
  output logic              a2R,
  input  logic              dump,
  output logic              busy,
  output logic [OUT_W-1:0]  g2Dat,
  output logic [BIN_AW-1:0] g2Idx,
  output logic              g2V,
  input  logic              g2R,
  output logic              g2Last
);
  localparam int NBINS  = 1 << BIN_AW;
  localparam int CENTER = 1 << (BIN_AW - 1);
  localparam int WP_W   = $clog2(WIN_DEPTH);
  localparam int WC_W   = WP_W + 1;

  g2_state_e          state, nstate;
  logic [TS_W-1:0]    win [WIN_DEPTH];
  logic [WP_W-1:0]    wr_ptr, scan_k;
  logic [WC_W-1:0]    win_cnt;
  logic [TS_W-1:0]    a1_q;
  logic [4:0]         shift_q;
  logic               drain_q, dump_pend, dvld;
  logic [BIN_AW-1:0]  idx;            // CLR address, then readout address
  logic               a1_acc, a2_acc, g2_acc, go_dump, scan_last;
  logic signed [TS_W:0] diff;
  g2_wide_t           bin_w;
  logic               bin_ok, inc_vld, clr_we, pipe_busy;
  logic [BIN_AW-1:0]  rd_addr;
  logic [CNT_W-1:0]   rd_data;

  assign a1_acc  = a1V & a1R;
  assign a2_acc  = a2V & a2R;
  assign g2_acc  = dvld & g2R;
  assign go_dump = dump_pend & ~pipe_busy;

  // While unfilled, live entries sit in slots 0..count-1; once full all slots
  // are live, so the scan walks physical slots directly.
  assign scan_last = ({1'b0, scan_k} == win_cnt - 1'b1);
  assign diff   = $signed({a1_q[TS_W-1], a1_q}) - $signed({win[scan_k][TS_W-1], win[scan_k]});
  assign bin_w  = g2_bin_of(g2_wide_t'(diff), shift_q, g2_wide_t'(CENTER));
  assign bin_ok = g2_in_range(bin_w, g2_wide_t'(NBINS));

  always_ff @(posedge clk or negedge RST)
    if (!RST) state <= CLR;
    else      state <= nstate;

  always_comb begin
    nstate = state;
    unique case (state)
      CLR:   if (idx == '1) nstate = IDLE;
      IDLE:  if (go_dump) nstate = DUMP;
             else if (a1_acc) nstate = (win_cnt != '0) ? SCAN : DRAIN;
      SCAN:  if (scan_last) nstate = DRAIN;
      DRAIN: if (drain_q) nstate = IDLE;
      DUMP:  if (g2_acc && idx == '1) nstate = IDLE;
      default: nstate = CLR;
    endcase
  end

  always_comb begin
    a1R     = 1'b0;
    a2R     = 1'b0;
    busy    = 1'b1;
    inc_vld = 1'b0;
    clr_we  = 1'b0;
    rd_addr = idx;
    case (state)
      CLR:  clr_we = 1'b1;
      IDLE: begin
        busy = 1'b0;
        if (!go_dump) begin
          a2R = 1'b1;
          a1R = ~a2V;
        end
      end
      SCAN: begin
        inc_vld = bin_ok;
        rd_addr = bin_w[BIN_AW-1:0];
      end
      DUMP: clr_we = g2_acc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) if (a2_acc) win[wr_ptr] <= a2;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      win_cnt   <= '0;
      scan_k    <= '0;
      a1_q      <= '0;
      shift_q   <= '0;
      drain_q   <= 1'b0;
      idx       <= '0;
      dump_pend <= 1'b0;
      dvld      <= 1'b0;
    end else begin
      // Full window: wr_ptr already points at the oldest entry.
      if (a2_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (win_cnt != WC_W'(WIN_DEPTH)) win_cnt <= win_cnt + 1'b1;
      end
      if (a1_acc) begin
        a1_q    <= a1;
        shift_q <= cfg_shift;
      end
      scan_k  <= (state == SCAN) ? scan_k + 1'b1 : '0;
      drain_q <= (state == DRAIN) && !drain_q;
      if (state == CLR || g2_acc) idx <= idx + 1'b1;
      if (state == IDLE && go_dump)      dump_pend <= 1'b0;
      else if (dump && state != DUMP)    dump_pend <= 1'b1;
      // Low for the read-latency cycle after entry and after each acceptance.
      dvld <= (state == DUMP) && !g2_acc;
    end
  end

  assign g2V    = dvld;
  assign g2Idx  = idx;
  assign g2Last = dvld && (idx == '1);
  assign g2Dat  = dvld ? OUT_W'(rd_data) : '0;

  g2_hist_bank #(.BIN_AW(BIN_AW), .CNT_W(CNT_W)) u_bank (
    .clk       (clk),
    .rst_n     (RST),
    .rd_addr   (rd_addr),
    .inc_vld   (inc_vld),
    .clr_we    (clr_we),
    .clr_addr  (idx),
    .rd_data   (rd_data),
    .pipe_busy (pipe_busy)
  );

endmodule

// File: tb/tb_g2_histogrammer.sv
module tb_g2_histogrammer;
  localparam int TS_W = 32, WIN_DEPTH = 16, BIN_AW = 10, CNT_W = 18, OUT_W = 32;
  localparam int NBINS = 1 << BIN_AW;

  logic clk = 0, RST = 0;
  logic [4:0] cfg_shift = 0;
  logic [TS_W-1:0] a1 = 0, a2 = 0;
  logic a1V = 0, a2V = 0, a1R, a2R, dump = 0, busy;
  logic [OUT_W-1:0] g2Dat;
  logic [BIN_AW-1:0] g2Idx;
  logic g2V, g2R = 0, g2Last;

  // narrow-counter instance for the saturate/wrap check
  logic [31:0] s_a1 = 0, s_a2 = 0;
  logic s_a1V = 0, s_a2V = 0, s_a1R, s_a2R, s_dump = 0, s_busy, s_v, s_r = 0, s_last;
  logic [7:0] s_dat;
  logic [3:0] s_idx;

  always #5 clk = ~clk;

  g2_histogrammer #(.TS_W(TS_W), .WIN_DEPTH(WIN_DEPTH), .BIN_AW(BIN_AW), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .RST(RST), .cfg_shift(cfg_shift),
    .a1(a1), .a1V(a1V), .a1R(a1R), .a2(a2), .a2V(a2V), .a2R(a2R),
    .dump(dump), .busy(busy), .g2Dat(g2Dat), .g2Idx(g2Idx), .g2V(g2V), .g2R(g2R), .g2Last(g2Last));

  g2_histogrammer #(.TS_W(32), .WIN_DEPTH(8), .BIN_AW(4), .CNT_W(2), .OUT_W(8)) u_sat (
    .clk(clk), .RST(RST), .cfg_shift(5'd0),
    .a1(s_a1), .a1V(s_a1V), .a1R(s_a1R), .a2(s_a2), .a2V(s_a2V), .a2R(s_a2R),
    .dump(s_dump), .busy(s_busy), .g2Dat(s_dat), .g2Idx(s_idx), .g2V(s_v), .g2R(s_r), .g2Last(s_last));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int mhist [NBINS];
  logic [31:0] mwin [$];

  task automatic m_clear();
    foreach (mhist[i]) mhist[i] = 0;
  endtask

  task automatic m_a2(input logic [31:0] v);
    mwin.push_back(v);
    if (mwin.size() > WIN_DEPTH) void'(mwin.pop_front());
  endtask

  task automatic m_a1(input logic [31:0] v, input int sh);
    foreach (mwin[k]) begin
      longint d, b;
      d = longint'($signed(v)) - longint'($signed(mwin[k]));
      b = (d >>> sh) + NBINS / 2;
      if (b >= 0 && b < NBINS) begin
`ifdef G2_HIST_SATURATE_EN
        if (mhist[b] < (1 << CNT_W) - 1) mhist[b]++;
`else
        mhist[b] = (mhist[b] + 1) % (1 << CNT_W);
`endif
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    int n;
    RST = 0; a1V = 0; a2V = 0; dump = 0; g2R = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a1R", a1R, 0);   chk("rst_a2R", a2R, 0);
    chk("rst_g2V", g2V, 0);   chk("rst_g2Last", g2Last, 0);
    chk("rst_g2Dat", g2Dat, 0); chk("rst_g2Idx", g2Idx, 0);
    chk("rst_busy", busy, 1);
    RST = 1;
    n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    chk("clr_busy_cycles", n, NBINS);
    chk("clr_a2R_up", a2R, 1);
    chk("clr_a1R_up", a1R, 1);
    m_clear();
    mwin.delete();
  endtask

  task automatic send_a2(input logic [31:0] v);
    bit acc;
    acc = 0;
    a2 = v; a2V = 1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk); acc = a2R;
      @(posedge clk); #1;
    end
    a2V = 0;
    chk("a2_accept", acc, 1);
    if (acc) m_a2(v);
  endtask

  task automatic send_a1(input logic [31:0] v, input int sh, output int lowc);
    bit acc;
    int n;
    acc = 0;
    a1 = v; cfg_shift = sh[4:0]; a1V = 1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = a1R;
      @(posedge clk); #1;
    end
    a1V = 0;
    cfg_shift = 5'($urandom);   // must have been captured at acceptance
    chk("a1_accept", acc, 1);
    n = 0;
    while (!a1R && n < 100) begin @(posedge clk); #1; n++; end
    lowc = n;
    chk("a1R_low_cycles", n, mwin.size() + 2);
    if (acc) m_a1(v, sh);
  endtask

  task automatic do_dump(input int stall_at, input bit rnd, output int nz_cnt, output int first_nz);
    int n, stall;
    nz_cnt = 0; first_nz = -1;
    dump = 1; @(posedge clk); #1; dump = 0;
    for (int i = 0; i < NBINS; i++) begin
      n = 0;
      while (!g2V && n < 20) begin @(posedge clk); #1; n++; end
      if (!g2V) begin chk("dump_valid_timeout", g2V, 1); break; end
      if (i > 0) chk("dump_gap", n, 1);
      chk("dump_idx", g2Idx, i);
      chk("dump_dat", g2Dat, mhist[i]);
      chk("dump_last", g2Last, i == NBINS - 1);
      if (g2Dat != 0) begin nz_cnt++; if (first_nz < 0) first_nz = i; end
      stall = (i == stall_at) ? 10 : (rnd ? int'($urandom_range(0, 2)) : 0);
      g2R = 0;
      repeat (stall) begin
        @(posedge clk); #1;
        chk("hold_v", g2V, 1);
        chk("hold_idx", g2Idx, i);
        chk("hold_dat", g2Dat, mhist[i]);
        chk("hold_last", g2Last, i == NBINS - 1);
      end
      g2R = 1; @(posedge clk); #1; g2R = 0;
    end
    m_clear();
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("dump_idle", busy, 0);
  endtask

  // ---------------- directed single-pair vectors ----------------
  typedef struct {
    logic [31:0] a2;
    logic [31:0] a1;
    int          sh;
    int          exp_bin;   // -1: pair discarded
  } vec_t;
  vec_t vecs [12];

  initial begin
    int nz, fz, lowc, n, acc, exp_sat;
    logic [31:0] base;

    vecs[0]  = '{32'd1000, 32'd1001, 0, 513};
    vecs[1]  = '{32'd0, 32'd600, 0, -1};
    vecs[2]  = '{32'd0, 32'd600, 1, 812};
    vecs[3]  = '{32'd600, 32'd0, 0, -1};
    vecs[4]  = '{32'd600, 32'd0, 1, 212};
    vecs[5]  = '{32'd100, 32'd611, 0, 1023};
    vecs[6]  = '{32'd100, 32'd612, 0, -1};
    vecs[7]  = '{32'd612, 32'd100, 0, 0};
    vecs[8]  = '{32'd613, 32'd100, 0, -1};
    vecs[9]  = '{32'd0, 32'h8000_0000, 31, 511};
    vecs[10] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 31, 513};
    vecs[11] = '{32'd17, 32'd10, 2, 510};

    // reset and an all-zero dump
    do_reset();
    do_dump(-1, 0, nz, fz);
    chk("zero_dump_nz", nz, 0);

    // three stops around one start, then a second dump must be empty
    send_a2(1000); send_a2(1001); send_a2(1002);
    send_a1(1001, 0, lowc);
    do_dump(-1, 0, nz, fz);
    chk("three_nz", nz, 3);
    chk("three_first", fz, 511);
    do_dump(-1, 0, nz, fz);
    chk("redump_nz", nz, 0);

    // four hits on one bin back-to-back (forwarding)
    do_reset();
    repeat (4) send_a2(500);
    send_a1(500, 0, lowc);
    chk("fwd_a1R_low", lowc, 6);
    chk("fwd_model_512", mhist[512], 4);
    do_dump(-1, 0, nz, fz);
    chk("fwd_nz", nz, 1);

    // window wrap: entries 0..3 evicted
    do_reset();
    for (int v = 0; v < 20; v++) send_a2(v);
    send_a1(19, 0, lowc);
    do_dump(-1, 0, nz, fz);
    chk("wrap_nz", nz, 16);
    chk("wrap_first", fz, 512);

    // table of single pairs
    for (int t = 0; t < 12; t++) begin
      do_reset();
      send_a2(vecs[t].a2);
      send_a1(vecs[t].a1, vecs[t].sh, lowc);
      do_dump(-1, 0, nz, fz);
      chk("vec_bin", fz, vecs[t].exp_bin);
      chk("vec_nz", nz, (vecs[t].exp_bin >= 0) ? 1 : 0);
    end

    // random traffic with random readout stalls and one long stall
    do_reset();
    base = $urandom;
    send_a1(base, 0, lowc);   // empty window
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 7) send_a2(base + $urandom_range(0, 600));
      else send_a1(base + $urandom_range(0, 600), int'($urandom_range(0, 3)), lowc);
    end
    do_dump(300, 1, nz, fz);

    // reset in the middle of a dump: window and bins are gone afterwards
    send_a2(7);
    send_a1(9, 0, lowc);
    dump = 1; @(posedge clk); #1; dump = 0;
    n = 0;
    while (!g2V && n < 20) begin @(posedge clk); #1; n++; end
    chk("middump_v", g2V, 1);
    g2R = 1; repeat (3) @(posedge clk); #1; g2R = 0;
    do_reset();
    send_a1(9, 0, lowc);
    do_dump(-1, 0, nz, fz);
    chk("after_rst_nz", nz, 0);

    // narrow counters: 5 hits on the centre bin of a 16-bin, 2-bit histogram
`ifdef G2_HIST_SATURATE_EN
    exp_sat = 3;
`else
    exp_sat = 1;
`endif
    s_a2 = 100; s_a2V = 1; acc = 0; n = 0;
    while (acc < 5 && n < 100) begin
      @(negedge clk); if (s_a2R) acc++;
      @(posedge clk); #1; n++;
    end
    s_a2V = 0;
    chk("sat_a2_count", acc, 5);
    s_a1 = 100; s_a1V = 1; acc = 0; n = 0;
    while (acc < 1 && n < 100) begin
      @(negedge clk); if (s_a1R) acc++;
      @(posedge clk); #1; n++;
    end
    s_a1V = 0;
    chk("sat_a1_count", acc, 1);
    n = 0;
    while (s_busy && n < 50) begin @(posedge clk); #1; n++; end
    chk("sat_idle", s_busy, 0);
    s_dump = 1; @(posedge clk); #1; s_dump = 0;
    s_r = 1;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (!s_v && n < 20) begin @(posedge clk); #1; n++; end
      if (!s_v) begin chk("sat_valid_timeout", s_v, 1); break; end
      chk("sat_idx", s_idx, i);
      chk("sat_dat", s_dat, (i == 8) ? exp_sat : 0);
      chk("sat_last", s_last, i == 15);
      @(posedge clk); #1;
    end
    s_r = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
